// File: rtl/overlay_feeder.sv
// overlay_feeder: splits one host stream into PE instructions, a coefficient
// strobe and blocks of PE_NUM data words, pacing each block with a PE_LAT
// drain wait followed by a one-cycle output-buffer load strobe.
// Ports:
//   clk, rst (async, active-low)    clock / reset
//   start, cfg_inst_cnt, cfg_blk_cnt job request and its configuration
//   s_valid, s_data, s_ready        host stream handshake (s_ready is decoded)
//   inst_in_v, inst_in              instruction beat to the array
//   alpha_v                         coefficient strobe
//   din_overlay_v, din_overlay      data beat to the array input buffer
//   load                            output-buffer parallel-load strobe
//   busy, done                      job status
module overlay_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int INST_WIDTH = 32,
  parameter int PE_NUM     = 8,
  parameter int PE_LAT     = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [7:0]                cfg_inst_cnt,
  input  logic [15:0]               cfg_blk_cnt,
  input  logic                      s_valid,
  input  logic [2*DATA_WIDTH-1:0]   s_data,
  output logic                      s_ready,
  output logic                      inst_in_v,
  output logic [INST_WIDTH-1:0]     inst_in,
  output logic                      alpha_v,
  output logic                      din_overlay_v,
  output logic [2*DATA_WIDTH-1:0]   din_overlay,
  output logic                      load,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned WORD_W = 2 * DATA_WIDTH;
  localparam int unsigned BEAT_W = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
  localparam int unsigned WAIT_W = $clog2(PE_LAT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INST  = 3'd1;
  localparam logic [2:0] S_ALPHA = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_LOAD  = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [7:0]            inst_total_q, inst_total_d;
  logic [7:0]            inst_cnt_q, inst_cnt_d;
  logic [15:0]           blk_rem_q, blk_rem_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  inst_in_v_d, alpha_v_d, din_v_d, load_d, busy_d, done_d;
  logic [INST_WIDTH-1:0] inst_in_d;
  logic [WORD_W-1:0]     din_d;
  logic                  hs;

  // Ready is a pure state decode so the host never sees a valid->ready path.
  assign s_ready = (state_q == S_INST) || (state_q == S_DATA);
  assign hs      = s_valid & s_ready;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next state, counters and next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    inst_total_d = inst_total_q;
    inst_cnt_d   = inst_cnt_q;
    blk_rem_d    = blk_rem_q;
    beat_d       = beat_q;
    wait_d       = wait_q;
    inst_in_v_d  = 1'b0;
    inst_in_d    = inst_in;
    alpha_v_d    = 1'b0;
    din_v_d      = 1'b0;
    din_d        = din_overlay;
    load_d       = 1'b0;
    busy_d       = busy;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_blk_cnt == 16'd0) begin
            // Empty job: acknowledge and stay idle.
            done_d = 1'b1;
          end else begin
            inst_total_d = cfg_inst_cnt;
            blk_rem_d    = cfg_blk_cnt;
            inst_cnt_d   = 8'd0;
            beat_d       = '0;
            wait_d       = '0;
            busy_d       = 1'b1;
            state_d      = (cfg_inst_cnt != 8'd0) ? S_INST : S_ALPHA;
          end
        end
      end
      S_INST: begin
        if (hs) begin
          inst_in_v_d = 1'b1;
          inst_in_d   = s_data[INST_WIDTH-1:0];
          if (inst_cnt_q == 8'(inst_total_q - 8'd1)) begin
            inst_cnt_d = 8'd0;
            state_d    = S_ALPHA;
          end else begin
            inst_cnt_d = 8'(inst_cnt_q + 8'd1);
          end
        end
      end
      // alpha_v lands one cycle after entry, clear of the last inst_in_v.
      S_ALPHA: begin
        alpha_v_d = 1'b1;
        state_d   = S_DATA;
      end
      S_DATA: begin
        if (hs) begin
          din_v_d = 1'b1;
          din_d   = s_data;
          if (beat_q == BEAT_W'(PE_NUM - 1)) begin
            beat_d  = '0;
            wait_d  = '0;
            state_d = S_WAIT;
          end else begin
            beat_d = BEAT_W'(beat_q + 1'b1);
          end
        end
      end
      S_WAIT: begin
        if (wait_q == WAIT_W'(PE_LAT - 1)) begin
          wait_d  = '0;
          state_d = S_LOAD;
        end else begin
          wait_d = WAIT_W'(wait_q + 1'b1);
        end
      end
      S_LOAD: begin
        load_d    = 1'b1;
        blk_rem_d = 16'(blk_rem_q - 16'd1);
        if (blk_rem_q == 16'd1) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_DATA;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counters, latched configuration and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_total_q  <= 8'd0;
      inst_cnt_q    <= 8'd0;
      blk_rem_q     <= 16'd0;
      beat_q        <= '0;
      wait_q        <= '0;
      inst_in_v     <= 1'b0;
      inst_in       <= '0;
      alpha_v       <= 1'b0;
      din_overlay_v <= 1'b0;
      din_overlay   <= '0;
      load          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      inst_total_q  <= inst_total_d;
      inst_cnt_q    <= inst_cnt_d;
      blk_rem_q     <= blk_rem_d;
      beat_q        <= beat_d;
      wait_q        <= wait_d;
      inst_in_v     <= inst_in_v_d;
      inst_in       <= inst_in_d;
      alpha_v       <= alpha_v_d;
      din_overlay_v <= din_v_d;
      din_overlay   <= din_d;
      load          <= load_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

endmodule

// File: tb/tb_overlay_feeder.sv
// Directed bench for overlay_feeder: reset, single and multi block jobs,
// empty job, host stalls, mid-job reset and start while busy.
module tb_overlay_feeder;

  localparam int DW     = 16;
  localparam int IW     = 32;
  localparam int PE_NUM = 8;
  localparam int PE_LAT = 12;
  localparam int MAXCYC = 2000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    cfg_inst_cnt = 8'd0;
  logic [15:0]   cfg_blk_cnt = 16'd0;
  logic          s_valid = 1'b0;
  logic [31:0]   s_data = 32'd0;
  logic          s_ready, inst_in_v, alpha_v, din_overlay_v, load, busy, done;
  logic [IW-1:0] inst_in;
  logic [31:0]   din_overlay;

  int tests_run = 0;
  int tests_failed = 0;

  // Per-job observations filled by run_job.
  int n_inst, n_alpha, n_din, n_load, n_done;
  int excl_err, gap_err, wait_err, lat_err, done_cyc;
  bit busy_seen, sready_seen, busy_at1, done_load, done_busy, alpha_order_ok, timed_out;
  logic [31:0] inst_log [0:15];
  logic [31:0] din_log  [0:63];

  overlay_feeder #(.DATA_WIDTH(DW), .INST_WIDTH(IW), .PE_NUM(PE_NUM), .PE_LAT(PE_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_inst_cnt(cfg_inst_cnt),
    .cfg_blk_cnt(cfg_blk_cnt), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .inst_in_v(inst_in_v), .inst_in(inst_in), .alpha_v(alpha_v),
    .din_overlay_v(din_overlay_v), .din_overlay(din_overlay), .load(load),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Drives one job and records what the array-side outputs did, cycle by cycle.
  task automatic run_job(input logic [7:0] ic, input logic [15:0] bc,
                         input bit toggle, input bit poke_wait);
    int cyc, ihs, dhs, wait_from;
    int hs_i [0:15];
    int hs_d [0:63];
    bit poked, hsn;
    n_inst = 0; n_alpha = 0; n_din = 0; n_load = 0; n_done = 0;
    excl_err = 0; gap_err = 0; wait_err = 0; lat_err = 0; done_cyc = -1;
    busy_seen = 0; sready_seen = 0; busy_at1 = 0; done_load = 0; done_busy = 1;
    alpha_order_ok = 0; timed_out = 0;
    ihs = 0; dhs = 0; wait_from = -1000; poked = 0;
    cfg_inst_cnt = ic; cfg_blk_cnt = bc; start = 1'b1; s_valid = 1'b0;
    @(posedge clk); #1;
    cyc = 1;
    while (cyc < MAXCYC) begin
      start = 1'b0;
      if (cyc == 1) busy_at1 = busy;
      if (inst_in_v) begin
        if (n_inst < 16) begin
          inst_log[n_inst] = inst_in;
          if (cyc != hs_i[n_inst] + 1) lat_err++;
        end
        n_inst++;
      end
      if (alpha_v) begin
        n_alpha++;
        alpha_order_ok = (n_inst == int'(ic)) && (n_din == 0);
      end
      if (din_overlay_v) begin
        if (n_din < 64) begin
          din_log[n_din] = din_overlay;
          if (cyc != hs_d[n_din] + 1) lat_err++;
        end
        n_din++;
      end
      if (load) begin
        n_load++;
        if (cyc - wait_from != PE_LAT + 2) gap_err++;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc; done_load = load; done_busy = busy;
      end
      if (busy) busy_seen = 1;
      if (s_ready) sready_seen = 1;
      if (int'(inst_in_v) + int'(alpha_v) + int'(din_overlay_v) + int'(load) > 1) excl_err++;
      if (cyc > wait_from && cyc <= wait_from + PE_LAT && s_ready) wait_err++;
      if (poke_wait && !poked && cyc == wait_from + 3) begin
        start = 1'b1; cfg_inst_cnt = 8'd3; cfg_blk_cnt = 16'd5; poked = 1;
      end
      if (n_done > 0 && cyc >= done_cyc + 4) break;
      s_valid = (n_done > 0) ? 1'b0 : (toggle ? ((cyc % 2) == 0) : 1'b1);
      s_data  = (ihs < int'(ic)) ? 32'hC0DE_0000 + 32'(ihs) : {16'(dhs + 1), 16'(dhs + 1)};
      hsn = s_valid && s_ready;
      if (hsn) begin
        if (ihs < int'(ic)) begin
          if (ihs < 16) hs_i[ihs] = cyc;
          ihs++;
        end else begin
          if (dhs < 64) hs_d[dhs] = cyc;
          dhs++;
          if (dhs % PE_NUM == 0) wait_from = cyc;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    timed_out = (n_done == 0);
    start = 1'b0; s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({s_ready, inst_in_v, alpha_v, din_overlay_v, load, busy, done} !== 7'd0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b want 0000000", {s_ready, inst_in_v, alpha_v, din_overlay_v, load, busy, done});
    end
    tests_run++;
    if ({inst_in, din_overlay} !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_data: inst_in=%h din_overlay=%h want 0", inst_in, din_overlay);
    end
    #2 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_job(8'd2, 16'd1, 1'b0, 1'b0);
    tests_run++; if (timed_out !== 1'b0) begin tests_failed++; $display("FAIL basic_timeout: no done within %0d cycles", MAXCYC); end
    tests_run++; if (busy_at1 !== 1'b1) begin tests_failed++; $display("FAIL basic_busy_after_start: got %b want 1", busy_at1); end
    tests_run++; if (n_inst !== 2) begin tests_failed++; $display("FAIL basic_inst_count: got %0d want 2", n_inst); end
    tests_run++; if (inst_log[0] !== 32'hC0DE_0000 || inst_log[1] !== 32'hC0DE_0001) begin
      tests_failed++; $display("FAIL basic_inst_values: got %h %h want c0de0000 c0de0001", inst_log[0], inst_log[1]); end
    tests_run++; if (n_alpha !== 1 || alpha_order_ok !== 1'b1) begin
      tests_failed++; $display("FAIL basic_alpha: count %0d order_ok %b want 1 1", n_alpha, alpha_order_ok); end
    tests_run++; if (n_din !== 8 || din_log[7] !== 32'h0008_0008) begin
      tests_failed++; $display("FAIL basic_data: count %0d last %h want 8 00080008", n_din, din_log[7]); end
    tests_run++; if (n_load !== 1 || gap_err !== 0) begin
      tests_failed++; $display("FAIL basic_load: count %0d gap_err %0d want 1 0", n_load, gap_err); end
    tests_run++; if (n_done !== 1 || done_load !== 1'b1 || done_busy !== 1'b0) begin
      tests_failed++; $display("FAIL basic_done: count %0d with_load %b busy %b want 1 1 0", n_done, done_load, done_busy); end
    tests_run++; if (excl_err !== 0 || lat_err !== 0) begin
      tests_failed++; $display("FAIL basic_excl_latency: excl %0d lat %0d want 0 0", excl_err, lat_err); end
  endtask

  task automatic test_multi_block();
    run_job(8'd0, 16'd3, 1'b0, 1'b0);
    tests_run++; if (timed_out !== 1'b0) begin tests_failed++; $display("FAIL multi_timeout: no done within %0d cycles", MAXCYC); end
    tests_run++; if (n_inst !== 0 || n_alpha !== 1) begin
      tests_failed++; $display("FAIL multi_inst_alpha: inst %0d alpha %0d want 0 1", n_inst, n_alpha); end
    tests_run++; if (n_din !== 24 || din_log[23] !== 32'h0018_0018) begin
      tests_failed++; $display("FAIL multi_data: count %0d last %h want 24 00180018", n_din, din_log[23]); end
    tests_run++; if (n_load !== 3 || gap_err !== 0) begin
      tests_failed++; $display("FAIL multi_load: count %0d gap_err %0d want 3 0", n_load, gap_err); end
    tests_run++; if (wait_err !== 0) begin
      tests_failed++; $display("FAIL multi_wait_ready: s_ready high in %0d wait cycles want 0", wait_err); end
    tests_run++; if (n_done !== 1 || excl_err !== 0) begin
      tests_failed++; $display("FAIL multi_done: done %0d excl %0d want 1 0", n_done, excl_err); end
  endtask

  task automatic test_zero_blocks();
    run_job(8'd5, 16'd0, 1'b0, 1'b0);
    tests_run++; if (done_cyc !== 1 || n_done !== 1) begin
      tests_failed++; $display("FAIL zero_done: cycle %0d count %0d want 1 1", done_cyc, n_done); end
    tests_run++; if (busy_seen !== 1'b0 || sready_seen !== 1'b0) begin
      tests_failed++; $display("FAIL zero_quiet: busy %b s_ready %b want 0 0", busy_seen, sready_seen); end
    tests_run++; if (n_inst + n_alpha + n_din + n_load !== 0) begin
      tests_failed++; $display("FAIL zero_no_pulses: got %0d pulses want 0", n_inst + n_alpha + n_din + n_load); end
  endtask

  task automatic test_stall();
    int bad;
    run_job(8'd0, 16'd1, 1'b1, 1'b0);
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (din_log[i] !== {16'(i + 1), 16'(i + 1)}) bad++;
    tests_run++; if (n_din !== 8 || bad !== 0) begin
      tests_failed++; $display("FAIL stall_sequence: count %0d bad %0d want 8 0", n_din, bad); end
    tests_run++; if (lat_err !== 0) begin
      tests_failed++; $display("FAIL stall_latency: %0d beats off by latency want 0", lat_err); end
    tests_run++; if (n_load !== 1 || n_done !== 1 || gap_err !== 0) begin
      tests_failed++; $display("FAIL stall_finish: load %0d done %0d gap %0d want 1 1 0", n_load, n_done, gap_err); end
  endtask

  task automatic test_abort();
    int seen, stray;
    seen = 0;
    cfg_inst_cnt = 8'd0; cfg_blk_cnt = 16'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 200 && seen < 5; c++) begin
      s_valid = 1'b1; s_data = 32'hDEAD_0000 + 32'(c);
      @(posedge clk); #1;
      if (din_overlay_v) seen++;
    end
    tests_run++; if (seen !== 5) begin tests_failed++; $display("FAIL abort_reach: beats %0d want 5", seen); end
    rst = 1'b0; s_valid = 1'b0;
    #1;
    tests_run++;
    if ({s_ready, busy, din_overlay_v, load, done} !== 5'd0 || din_overlay !== 32'd0) begin
      tests_failed++;
      $display("FAIL abort_async_clear: ctrl %b data %h want 00000 0", {s_ready, busy, din_overlay_v, load, done}, din_overlay);
    end
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (load || done || busy) stray++;
    end
    tests_run++; if (stray !== 0) begin tests_failed++; $display("FAIL abort_stray: %0d cycles with load/done/busy want 0", stray); end
    run_job(8'd0, 16'd1, 1'b0, 1'b0);
    tests_run++; if (n_din !== 8 || din_log[0] !== 32'h0001_0001) begin
      tests_failed++; $display("FAIL abort_new_job_data: count %0d first %h want 8 00010001", n_din, din_log[0]); end
    tests_run++; if (n_load !== 1 || n_done !== 1) begin
      tests_failed++; $display("FAIL abort_new_job_finish: load %0d done %0d want 1 1", n_load, n_done); end
  endtask

  task automatic test_start_in_wait();
    run_job(8'd1, 16'd1, 1'b0, 1'b1);
    tests_run++; if (n_inst !== 1 || n_alpha !== 1 || n_din !== 8) begin
      tests_failed++; $display("FAIL busy_start_counts: inst %0d alpha %0d din %0d want 1 1 8", n_inst, n_alpha, n_din); end
    tests_run++; if (n_load !== 1 || n_done !== 1 || gap_err !== 0) begin
      tests_failed++; $display("FAIL busy_start_finish: load %0d done %0d gap %0d want 1 1 0", n_load, n_done, gap_err); end
    tests_run++; if (busy !== 1'b0 || s_ready !== 1'b0) begin
      tests_failed++; $display("FAIL busy_start_idle: busy %b s_ready %b want 0 0", busy, s_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi_block();
    test_zero_blocks();
    test_stall();
    test_abort();
    test_start_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
